// File: rtl/cpu_sequencer.sv
// -----------------------------------------------------------------------------
// cpu_sequencer
//
// Multi-cycle control sequencer for the J17 processor. Each instruction is
// stepped through FETCH -> DECODE -> EXECUTE -> (WAIT_ALU | STACK) ->
// WRITEBACK. The sequencer drives the datapath strobes, owns the hardware
// stack pointer, and parks in HALT on HLT, illegal opcodes, stack
// overflow/underflow or a hung multi-cycle ALU operation.
//
// Ports
//   clock       : sole clock, rising edge
//   reset       : synchronous, active-high
//   mem_ready   : instruction memory word valid this cycle
//   opcode      : instruction[31:26], stable from DECODE until next ir_load
//   alu_done    : multi-cycle ALU result valid
//   ir_load     : load instruction register (FETCH and mem_ready)
//   pc_write    : PC unit applies pcControl (WRITEBACK)
//   reg_write   : register file write enable (WRITEBACK, writing classes)
//   alu_start   : one-cycle start pulse for multi-cycle ALU ops
//   stack_push  : stack write strobe
//   stack_pop   : stack read strobe
//   sp          : stack occupancy, 0..STACK_DEPTH
//   halted      : sequencer is in HALT
//   fault       : HALT was entered because of an error
//   fault_code  : 0 none, 1 overflow, 2 underflow, 3 ALU timeout
//   state       : current state, for debug
// -----------------------------------------------------------------------------
module cpu_sequencer #(
   parameter int STACK_DEPTH = 16,
   parameter int ALU_TIMEOUT = 32,
   localparam int SPW = $clog2(STACK_DEPTH) + 1
) (
   input  logic           clock,
   input  logic           reset,
   input  logic           mem_ready,
   input  logic [5:0]     opcode,
   input  logic           alu_done,
   output logic           ir_load,
   output logic           pc_write,
   output logic           reg_write,
   output logic           alu_start,
   output logic           stack_push,
   output logic           stack_pop,
   output logic [SPW-1:0] sp,
   output logic           halted,
   output logic           fault,
   output logic [1:0]     fault_code,
   output logic [2:0]     state
);

   // Wide enough to hold ALU_TIMEOUT-1 for any parameter value >= 1.
   localparam int TW = $clog2(ALU_TIMEOUT + 1);

   localparam logic [5:0] OP_MUL  = 6'd2;
   localparam logic [5:0] OP_DIV  = 6'd3;
   localparam logic [5:0] OP_MULI = 6'd6;
   localparam logic [5:0] OP_DIVI = 6'd7;
   localparam logic [5:0] OP_MOD  = 6'd12;
   localparam logic [5:0] OP_MOV  = 6'd24;
   localparam logic [5:0] OP_HLT  = 6'd26;
   localparam logic [5:0] OP_PUSH = 6'd27;
   localparam logic [5:0] OP_POP  = 6'd28;
   localparam logic [5:0] OP_MOVI = 6'd29;

   localparam logic [1:0] FC_NONE  = 2'd0;
   localparam logic [1:0] FC_OVER  = 2'd1;
   localparam logic [1:0] FC_UNDER = 2'd2;
   localparam logic [1:0] FC_TMO   = 2'd3;

   typedef enum logic [2:0] {
      S_FETCH     = 3'd0,
      S_DECODE    = 3'd1,
      S_EXECUTE   = 3'd2,
      S_WAIT_ALU  = 3'd3,
      S_STACK     = 3'd4,
      S_WRITEBACK = 3'd5,
      S_HALT      = 3'd6
   } state_t;

   state_t         st_q, st_d;
   logic [5:0]     op_q;
   logic [TW-1:0]  tmo_q, tmo_d;
   logic [SPW-1:0] sp_q, sp_d;
   logic           fault_q, fault_d;
   logic [1:0]     code_q, code_d;

   // raw strobes before reset gating
   logic ir_raw, pc_raw, rw_raw, as_raw, pu_raw, po_raw;

   function automatic logic is_mc(input logic [5:0] op);
      return (op == OP_MUL) || (op == OP_DIV) || (op == OP_MULI) ||
             (op == OP_DIVI) || (op == OP_MOD);
   endfunction

   function automatic logic is_illegal(input logic [5:0] op);
      return op >= 6'd30;
   endfunction

   // Single-cycle ALU (0..14 minus MC) and MC together cover 0..14.
   function automatic logic writes_reg(input logic [5:0] op);
      return (op <= 6'd14) || (op == OP_MOV) || (op == OP_MOVI) ||
             (op == OP_POP);
   endfunction

   // ---------------------------------------------------------------------------
   // State and datapath registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clock) begin
      if (reset) begin
         st_q    <= S_FETCH;
         op_q    <= '0;
         tmo_q   <= '0;
         sp_q    <= '0;
         fault_q <= 1'b0;
         code_q  <= FC_NONE;
      end else begin
         st_q    <= st_d;
         tmo_q   <= tmo_d;
         sp_q    <= sp_d;
         fault_q <= fault_d;
         code_q  <= code_d;
         // Opcode is valid from DECODE on; latch it so later states decode
         // from a register rather than the IR path.
         if (st_q == S_DECODE) op_q <= opcode;
      end
   end

   // ---------------------------------------------------------------------------
   // Next-state and strobe decode
   // ---------------------------------------------------------------------------
   always_comb begin
      st_d    = st_q;
      tmo_d   = tmo_q;
      sp_d    = sp_q;
      fault_d = fault_q;
      code_d  = code_q;
      ir_raw  = 1'b0;
      pc_raw  = 1'b0;
      rw_raw  = 1'b0;
      as_raw  = 1'b0;
      pu_raw  = 1'b0;
      po_raw  = 1'b0;

      case (st_q)
         S_FETCH: begin
            ir_raw = mem_ready;
            if (mem_ready) st_d = S_DECODE;
         end

         S_DECODE: begin
            // Illegal opcodes behave as HLT: clean halt, no fault flagged.
            if ((opcode == OP_HLT) || is_illegal(opcode)) st_d = S_HALT;
            else                                          st_d = S_EXECUTE;
         end

         S_EXECUTE: begin
            if (is_mc(op_q)) begin
               as_raw = 1'b1;
               tmo_d  = '0;
               st_d   = S_WAIT_ALU;
            end else if ((op_q == OP_PUSH) && (sp_q == SPW'(STACK_DEPTH))) begin
               fault_d = 1'b1;
               code_d  = FC_OVER;
               st_d    = S_HALT;
            end else if ((op_q == OP_POP) && (sp_q == '0)) begin
               fault_d = 1'b1;
               code_d  = FC_UNDER;
               st_d    = S_HALT;
            end else if ((op_q == OP_PUSH) || (op_q == OP_POP)) begin
               st_d = S_STACK;
            end else begin
               st_d = S_WRITEBACK;
            end
         end

         S_WAIT_ALU: begin
            // alu_done wins over a timeout landing in the same cycle.
            if (alu_done) begin
               st_d = S_WRITEBACK;
            end else if (tmo_q == TW'(ALU_TIMEOUT - 1)) begin
               fault_d = 1'b1;
               code_d  = FC_TMO;
               st_d    = S_HALT;
            end else begin
               tmo_d = tmo_q + TW'(1);
            end
         end

         S_STACK: begin
            // Bounds were checked in EXECUTE, so sp cannot wrap here.
            if (op_q == OP_PUSH) begin
               pu_raw = 1'b1;
               sp_d   = sp_q + SPW'(1);
            end else begin
               po_raw = 1'b1;
               sp_d   = sp_q - SPW'(1);
            end
            st_d = S_WRITEBACK;
         end

         S_WRITEBACK: begin
            pc_raw = 1'b1;
            rw_raw = writes_reg(op_q);
            st_d   = S_FETCH;
         end

         S_HALT: begin
            st_d = S_HALT;
         end

         default: begin
            st_d = S_FETCH;
         end
      endcase
   end

   // A reset landing mid-instruction must not let the aborted instruction
   // strobe the datapath. ir_load is left alone: reloading the IR while
   // FETCH is being held is harmless.
   assign ir_load    = ir_raw;
   assign pc_write   = pc_raw & ~reset;
   assign reg_write  = rw_raw & ~reset;
   assign alu_start  = as_raw & ~reset;
   assign stack_push = pu_raw & ~reset;
   assign stack_pop  = po_raw & ~reset;

   assign sp         = sp_q;
   assign halted     = (st_q == S_HALT);
   assign fault      = fault_q;
   assign fault_code = code_q;
   assign state      = st_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
module tb_cpu_sequencer;

  logic       clk;
  logic       reset;
  logic       mem_ready;
  logic [5:0] opcode;
  logic       alu_done;
  logic       ir_load, pc_write, reg_write, alu_start, stack_push, stack_pop;
  logic [4:0] sp;
  logic       halted, fault;
  logic [1:0] fault_code;
  logic [2:0] state;

  cpu_sequencer dut (
    .clock      (clk),
    .reset      (reset),
    .mem_ready  (mem_ready),
    .opcode     (opcode),
    .alu_done   (alu_done),
    .ir_load    (ir_load),
    .pc_write   (pc_write),
    .reg_write  (reg_write),
    .alu_start  (alu_start),
    .stack_push (stack_push),
    .stack_pop  (stack_pop),
    .sp         (sp),
    .halted     (halted),
    .fault      (fault),
    .fault_code (fault_code),
    .state      (state)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] st;
    logic [5:0] stb;
    logic [4:0] sp;
    logic       h;
    logic       f;
    logic [1:0] c;
  } exp_t;

  localparam logic [2:0] F = 3'd0, D = 3'd1, E = 3'd2, W = 3'd3,
                         K = 3'd4, B = 3'd5, H = 3'd6;
  localparam logic [5:0] N  = 6'b000000, IR = 6'b100000, PC = 6'b010000,
                         PR = 6'b011000, AS = 6'b000100, PU = 6'b000010,
                         PO = 6'b000001;

  exp_t sbq[$];
  int   nvec  = 0;
  int   nfail = 0;
  int   xsp   = 0;

  always @(negedge clk) begin
    exp_t e;
    exp_t a;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      a = {state, ir_load, pc_write, reg_write, alu_start, stack_push,
           stack_pop, sp, halted, fault, fault_code};
      nvec++;
      if (a !== e) begin
        nfail++;
        $display("FAIL vec%0d: got st=%0d stb=%b sp=%0d h=%b f=%b c=%0d, want st=%0d stb=%b sp=%0d h=%b f=%b c=%0d",
                 nvec, a.st, a.stb, a.sp, a.h, a.f, a.c,
                 e.st, e.stb, e.sp, e.h, e.f, e.c);
      end
    end
  end

  task automatic chk(input bit ok, input string what);
    if (!ok) begin
      nfail++;
      $display("FAIL %s: st=%0d stb=%b sp=%0d h=%b f=%b c=%0d", what, state,
               {ir_load, pc_write, reg_write, alu_start, stack_push, stack_pop},
               sp, halted, fault, fault_code);
    end
  endtask

  task automatic cyc(input logic r, input logic m, input logic [5:0] o,
                     input logic ad, input logic [2:0] s, input logic [5:0] b,
                     input int esp, input logic h, input logic f,
                     input logic [1:0] c);
    exp_t e;
    reset     = r;
    mem_ready = m;
    opcode    = o;
    alu_done  = ad;
    e.st  = s;
    e.stb = b;
    e.sp  = 5'(esp);
    e.h   = h;
    e.f   = f;
    e.c   = c;
    sbq.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic fetch_dec(input logic [5:0] o);
    cyc(0, 1, o, 0, F, IR, xsp, 0, 0, 0);
    cyc(0, 1, o, 0, D, N,  xsp, 0, 0, 0);
  endtask

  task automatic simple(input logic [5:0] o, input logic rw);
    fetch_dec(o);
    cyc(0, 1, o, 0, E, N, xsp, 0, 0, 0);
    cyc(0, 1, o, 0, B, rw ? PR : PC, xsp, 0, 0, 0);
  endtask

  task automatic push_ok();
    fetch_dec(6'd27);
    cyc(0, 1, 6'd27, 0, E, N,  xsp, 0, 0, 0);
    cyc(0, 1, 6'd27, 0, K, PU, xsp, 0, 0, 0);
    xsp++;
    cyc(0, 1, 6'd27, 0, B, PC, xsp, 0, 0, 0);
  endtask

  task automatic pop_ok();
    fetch_dec(6'd28);
    cyc(0, 1, 6'd28, 0, E, N,  xsp, 0, 0, 0);
    cyc(0, 1, 6'd28, 0, K, PO, xsp, 0, 0, 0);
    xsp--;
    cyc(0, 1, 6'd28, 0, B, PR, xsp, 0, 0, 0);
  endtask

  task automatic mc(input logic [5:0] o, input int k);
    fetch_dec(o);
    cyc(0, 1, o, 1, E, AS, xsp, 0, 0, 0);
    for (int i = 0; i < k - 1; i++) cyc(0, 1, o, 0, W, N, xsp, 0, 0, 0);
    cyc(0, 1, o, 1, W, N,  xsp, 0, 0, 0);
    cyc(0, 1, o, 0, B, PR, xsp, 0, 0, 0);
  endtask

  task automatic do_reset(input logic [2:0] s, input logic h, input logic f,
                          input logic [1:0] c);
    cyc(1, 0, 6'd0, 0, s, N, xsp, h, f, c);
    xsp = 0;
    cyc(0, 0, 6'd0, 0, F, N, 0, 0, 0, 0);
  endtask

  initial begin
    reset = 1'b1; mem_ready = 1'b0; opcode = '0; alu_done = 1'b0;
    @(posedge clk);
    #1;

    cyc(1, 0, 6'd0, 0, F, N, 0, 0, 0, 0);
    chk(state === 3'd0 && sp === 5'd0 && halted === 1'b0 && fault === 1'b0 &&
        fault_code === 2'd0 &&
        {ir_load, pc_write, reg_write, alu_start, stack_push, stack_pop} === 6'b0,
        "reset state");
    cyc(0, 0, 6'd0, 0, F, N, 0, 0, 0, 0);

    simple(6'd0,  1);
    simple(6'd22, 0);
    simple(6'd25, 0);
    simple(6'd24, 1);
    simple(6'd29, 1);
    simple(6'd14, 1);

    for (int i = 0; i < 16; i++) push_ok();
    fetch_dec(6'd27);
    cyc(0, 1, 6'd27, 0, E, N, 16, 0, 0, 0);
    cyc(0, 1, 6'd27, 0, H, N, 16, 1, 1, 1);
    cyc(0, 1, 6'd27, 0, H, N, 16, 1, 1, 1);
    do_reset(H, 1, 1, 1);

    fetch_dec(6'd28);
    cyc(0, 1, 6'd28, 0, E, N, 0, 0, 0, 0);
    cyc(0, 1, 6'd28, 0, H, N, 0, 1, 1, 2);
    cyc(0, 1, 6'd28, 0, H, N, 0, 1, 1, 2);
    do_reset(H, 1, 1, 2);

    push_ok();
    pop_ok();

    mc(6'd3, 5);
    mc(6'd2, 1);
    mc(6'd12, 32);

    fetch_dec(6'd3);
    cyc(0, 1, 6'd3, 0, E, AS, 0, 0, 0, 0);
    for (int i = 0; i < 32; i++) cyc(0, 1, 6'd3, 0, W, N, 0, 0, 0, 0);
    cyc(0, 1, 6'd3, 0, H, N, 0, 1, 1, 3);
    chk(state === 3'd6 && halted === 1'b1 && fault === 1'b1 &&
        fault_code === 2'd3 && sp === 5'd0 && alu_start === 1'b0,
        "expired ALU wait");
    cyc(0, 1, 6'd3, 0, H, N, 0, 1, 1, 3);
    do_reset(H, 1, 1, 3);

    cyc(0, 1, 6'd26, 0, F, IR, 0, 0, 0, 0);
    cyc(0, 1, 6'd26, 0, D, N,  0, 0, 0, 0);
    cyc(0, 1, 6'd26, 0, H, N,  0, 1, 0, 0);
    cyc(0, 1, 6'd26, 0, H, N,  0, 1, 0, 0);
    do_reset(H, 1, 0, 0);
    cyc(0, 1, 6'd45, 0, F, IR, 0, 0, 0, 0);
    cyc(0, 1, 6'd45, 0, D, N,  0, 0, 0, 0);
    cyc(0, 1, 6'd45, 0, H, N,  0, 1, 0, 0);
    do_reset(H, 1, 0, 0);

    fetch_dec(6'd3);
    cyc(0, 1, 6'd3, 0, E, AS, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 1, 6'd3, 0, W, N, 0, 0, 0, 0);
    do_reset(W, 0, 0, 0);
    simple(6'd1, 1);

    @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    if (nfail == 0) $display("PASS");
    else            $display("FAIL");
    $finish;
  end

endmodule
